// File: rtl/alu_pkg.sv
// Shared definitions for the serial negator.
//   mode_t  : operation select (NEG, ABS, ONES, PASS)
//   state_t : control FSM encoding (IDLE, RUN, DONE)
//   eff_mode: resolves ABS into the per-bit rule actually applied
package alu_pkg;

    typedef enum logic [1:0] {
        NEG  = 2'd0,
        ABS  = 2'd1,
        ONES = 2'd2,
        PASS = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ABS is NEG for a negative operand and PASS otherwise; the bit cell
    // never sees ABS itself.
    function automatic mode_t eff_mode(input mode_t m, input logic msb);
        if (m == ABS) return msb ? NEG : PASS;
        return m;
    endfunction

endpackage

// File: rtl/neg_bit_cell.sv
// One bit of the serial operation, purely combinational.
//   b             : current operand bit (LSB first)
//   seen_one      : a 1 has already appeared in a lower bit
//   mode_eff      : NEG, ONES or PASS (ABS already resolved)
//   out_bit       : result bit
//   seen_one_next : updated seen_one for the next bit
module neg_bit_cell
    import alu_pkg::*;
(
    input  logic  b,
    input  logic  seen_one,
    input  mode_t mode_eff,
    output logic  out_bit,
    output logic  seen_one_next
);

    always_comb begin
        out_bit       = b;
        seen_one_next = seen_one;
        case (mode_eff)
            // Two's complement: copy up to and including the first 1,
            // invert everything above it.
            NEG: begin
                out_bit       = seen_one ? ~b : b;
                seen_one_next = seen_one | b;
            end
            ONES:    out_bit = ~b;
            default: out_bit = b;
        endcase
    end

endmodule

// File: rtl/serial_negator.sv
// Bit-serial negate / abs / one's complement / pass unit.
//   clk, rst : clock, synchronous active-high reset
//   start    : request, taken only when not busy
//   mode     : 0=NEG 1=ABS 2=ONES 3=PASS
//   operand  : two's-complement input, captured with start
//   busy     : high during the WIDTH processing cycles
//   done     : one-cycle pulse when result/ovf/zero are updated
//   result   : result, held until the next operation completes
//   ovf      : NEG/ABS of the most-negative value
//   zero     : result is all zeros
module serial_negator
    import alu_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             seen_one;
    mode_t            mode_q;
    logic [WIDTH-1:0] op_q;     // untouched copy for ABS sign and ovf
    logic [WIDTH-1:0] op_sh;    // shifted right each cycle, bit 0 is current
    logic [WIDTH-2:0] sr_q;     // result bits gathered so far, MSB-aligned

    logic             out_bit;
    logic             seen_one_next;
    logic [WIDTH-1:0] sr_nxt;

    neg_bit_cell u_cell (
        .b             (op_sh[0]),
        .seen_one      (seen_one),
        .mode_eff      (eff_mode(mode_q, op_q[WIDTH-1])),
        .out_bit       (out_bit),
        .seen_one_next (seen_one_next)
    );

    // New bit enters at the top; after WIDTH shifts the first bit is at LSB.
    assign sr_nxt = {out_bit, sr_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            seen_one <= 1'b0;
            mode_q   <= NEG;
            op_q     <= '0;
            op_sh    <= '0;
            sr_q     <= '0;
            result   <= '0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    sr_q     <= sr_nxt[WIDTH-1:1];
                    op_sh    <= op_sh >> 1;
                    seen_one <= seen_one_next;
                    cnt      <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= sr_nxt;
                        zero   <= (sr_nxt == '0);
                        ovf    <= (mode_q == NEG || mode_q == ABS) && (op_q == MIN_NEG);
                    end
                end
                default: begin  // IDLE, DONE
                    done <= 1'b0;
                    if (start) begin
                        op_q     <= operand;
                        op_sh    <= operand;
                        mode_q   <= mode_t'(mode);
                        cnt      <= '0;
                        seen_one <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
